// File: rtl/dmem_bus_arbiter.sv
// DataMemory port arbiter between the MEM stage and a DMA requester.
// CPU owns the port by default; a starvation counter forces a DMA slot.
module dmem_bus_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int STARVE_MAX = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic              dma_err,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {IDLE, ACK} state_t;

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] starve_cnt;

    logic cpu_mem;
    logic dma_bad;
    logic dma_elig;
    logic err_grant;
    logic opp_grant;
    logic forced_grant;
    logic grant;
    logic dma_drive;

    // Peripheral accesses (bit 30) never touch the data memory port
    assign cpu_mem      = (cpu_rd | cpu_wr) & ~cpu_addr[30];
    assign dma_bad      = dma_addr[30];
    assign dma_elig     = dma_req & (state == IDLE);
    assign err_grant    = dma_elig & dma_bad;
    assign opp_grant    = dma_elig & ~dma_bad & ~cpu_mem;
    assign forced_grant = dma_elig & ~dma_bad & cpu_mem
                        & (starve_cnt == STARVE_LIM);
    assign grant        = err_grant | opp_grant | forced_grant;
    assign dma_drive    = opp_grant | forced_grant;

    assign cpu_rdata = mem_rdata;
    assign dma_ack   = (state == ACK);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (grant) state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_rd    = cpu_rd & ~cpu_addr[30];
        mem_wr    = cpu_wr & ~cpu_addr[30];
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        cpu_stall = forced_grant;
        if (dma_drive) begin
            mem_rd    = ~dma_we;
            mem_wr    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end
        if (reset) begin
            mem_rd    = 1'b0;
            mem_wr    = 1'b0;
            cpu_stall = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dma_err   <= 1'b0;
            dma_rdata <= '0;
        end else if (grant) begin
            dma_err   <= dma_bad;
            dma_rdata <= (dma_drive & ~dma_we) ? mem_rdata : '0;
        end else begin
            dma_err   <= 1'b0;
        end
    end

    // Counts denied cycles; the grant at STARVE_MAX stalls the CPU once
    always_ff @(posedge clk) begin
        if (reset || grant || state == ACK || !dma_req) begin
            starve_cnt <= '0;
        end else if (dma_elig && cpu_mem && starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Directed bench for dmem_bus_arbiter with a small behavioural memory.
// Inputs change 1 after posedge; outputs are checked on the negedge.
module tb_dmem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        dma_req;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_ack;
    logic        dma_err;
    logic [31:0] dma_rdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [256];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_bus_arbiter #(
        .DATA_W(32), .ADDR_W(32), .STARVE_MAX(7)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_err(dma_err), .dma_rdata(dma_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr[9:2]] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        cpu_rd    = 1'b0;
        cpu_wr    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        dma_req   = 1'b0;
        dma_we    = 1'b0;
        dma_addr  = '0;
        dma_wdata = '0;
    endtask

    task automatic dma_set(input logic we, input logic [31:0] a,
                           input logic [31:0] d);
        dma_req   = 1'b1;
        dma_we    = we;
        dma_addr  = a;
        dma_wdata = d;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        reset = 1'b1;
        idle_in();
        cpu_rd   = 1'b1;
        cpu_addr = 32'h20;
        tick();
        tick();
        @(negedge clk);
        chk("rst_ack", dma_ack, 0);
        chk("rst_err", dma_err, 0);
        chk("rst_rdata", dma_rdata, 0);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_stall", cpu_stall, 0);
        tick();

        // opportunistic write then read-back
        reset = 1'b0;
        idle_in();
        dma_set(1'b1, 32'h10, 32'hDEADBEEF);
        @(negedge clk);
        chk("w_mem_wr", mem_wr, 1);
        chk("w_mem_addr", mem_addr, 32'h10);
        chk("w_mem_wdata", mem_wdata, 32'hDEADBEEF);
        chk("w_stall", cpu_stall, 0);
        chk("w_ack_early", dma_ack, 0);
        tick();
        dma_req = 1'b0;
        @(negedge clk);
        chk("w_ack", dma_ack, 1);
        chk("w_err", dma_err, 0);
        chk("w_rdata", dma_rdata, 0);
        tick();
        dma_set(1'b0, 32'h10, 32'h0);
        @(negedge clk);
        chk("r_mem_rd", mem_rd, 1);
        chk("r_mem_addr", mem_addr, 32'h10);
        tick();
        dma_req = 1'b0;
        @(negedge clk);
        chk("r_ack", dma_ack, 1);
        chk("r_rdata", dma_rdata, 32'hDEADBEEF);
        tick();

        // starvation: forced grant every 9 cycles
        cpu_rd   = 1'b1;
        cpu_addr = 32'h20;
        dma_set(1'b0, 32'h10, 32'h0);
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            chk($sformatf("sv_stall%0d", i), cpu_stall, (i % 9) == 7);
            chk($sformatf("sv_ack%0d", i), dma_ack, (i % 9) == 8);
            chk($sformatf("sv_addr%0d", i), mem_addr,
                ((i % 9) == 7) ? 32'h10 : 32'h20);
            if ((i % 9) == 8) chk("sv_rdata", dma_rdata, 32'hDEADBEEF);
            tick();
        end
        idle_in();

        // CPU peripheral write alongside DMA write
        cpu_wr    = 1'b1;
        cpu_addr  = 32'h40000010;
        cpu_wdata = 32'h11111111;
        dma_set(1'b1, 32'h30, 32'hCAFEF00D);
        @(negedge clk);
        chk("pw_mem_wr", mem_wr, 1);
        chk("pw_addr", mem_addr, 32'h30);
        chk("pw_wdata", mem_wdata, 32'hCAFEF00D);
        chk("pw_stall", cpu_stall, 0);
        tick();
        dma_req = 1'b0;
        @(negedge clk);
        chk("pw_ack", dma_ack, 1);
        chk("pw_cpu_wr", mem_wr, 0);
        tick();
        idle_in();

        // error access
        dma_set(1'b0, 32'h40000000, 32'h0);
        @(negedge clk);
        chk("e_mem_rd", mem_rd, 0);
        chk("e_mem_wr", mem_wr, 0);
        chk("e_stall", cpu_stall, 0);
        tick();
        dma_req = 1'b0;
        @(negedge clk);
        chk("e_ack", dma_ack, 1);
        chk("e_err", dma_err, 1);
        chk("e_rdata", dma_rdata, 0);
        tick();

        // back-to-back DMA writes, CPU idle
        dma_set(1'b1, 32'h40, 32'h55);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("bb_wr%0d", i), mem_wr, (i % 2) == 0);
            chk($sformatf("bb_ack%0d", i), dma_ack, (i % 2) == 1);
            tick();
        end
        idle_in();
        @(negedge clk);
        chk("bb_mem", mem[16], 32'h55);
        tick();

        // reset landing on a forced grant
        cpu_rd   = 1'b1;
        cpu_addr = 32'h20;
        dma_set(1'b1, 32'h50, 32'h77);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk($sformatf("rf_deny%0d", i), cpu_stall, 0);
            tick();
        end
        reset = 1'b1;
        @(negedge clk);
        chk("rf_mem_wr", mem_wr, 0);
        chk("rf_mem_rd", mem_rd, 0);
        chk("rf_stall", cpu_stall, 0);
        tick();
        reset = 1'b0;
        for (int j = 0; j < 9; j++) begin
            @(negedge clk);
            if (j == 0) chk("rf_no_ack", dma_ack, 0);
            chk($sformatf("rf_stall%0d", j), cpu_stall, j == 7);
            chk($sformatf("rf_wr%0d", j), mem_wr, j == 7);
            tick();
        end
        idle_in();
        @(negedge clk);
        chk("rf_mem", mem[20], 32'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
